// File: rtl/gate_tester_if.sv
// Signal bundle between gate_tester and its environment: run control,
// the drive/return path to the gate under test, and the run results.
interface gate_tester_if;
  logic       start;
  logic       dut_a;
  logic       dut_b;
  logic       dut_z;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] fail_cnt;
  logic [1:0] fail_vec;

  // Tester side: issues vectors, reports results.
  modport master (
    input  start, dut_z,
    output dut_a, dut_b, busy, done, pass, fail_cnt, fail_vec
  );

  // Environment side: requests runs, returns the gate output.
  modport slave (
    output start, dut_z,
    input  dut_a, dut_b, busy, done, pass, fail_cnt, fail_vec
  );
endinterface

// File: rtl/gate_tester.sv
// Exhaustive 2-input gate tester: walks v = 0..3, settles, compares dut_z to EXPECTED[v].
// Define GATE_TESTER_FAILVEC_EN to build the first-failing-vector capture on fail_vec.
//
// state  | meaning
// IDLE   | waiting for start; results of last run held
// SETTLE | vector v applied, counting down settle time
// SAMPLE | vector v applied, dut_z compared this cycle
// DONE   | one-cycle completion pulse, pass valid
module gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED      = 4'b1110
) (
  input  logic          clk,
  input  logic          rst,
  gate_tester_if.master gt
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] v_q, v_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] fail_cnt_q, fail_cnt_d;
  logic       pass_q, pass_d;
  logic       mismatch;
  logic       first_mismatch;

  assign mismatch       = (state_q == SAMPLE) && (gt.dut_z != EXPECTED[v_q]);
  assign first_mismatch = mismatch && (fail_cnt_q == 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      v_q        <= 2'd0;
      cnt_q      <= 4'd0;
      fail_cnt_q <= 3'd0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      cnt_q      <= cnt_d;
      fail_cnt_q <= fail_cnt_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    v_d        = v_q;
    cnt_d      = cnt_q;
    fail_cnt_d = fail_cnt_q;
    pass_d     = pass_q;
    case (state_q)
      IDLE: begin
        if (gt.start) begin
          state_d    = SETTLE;
          v_d        = 2'd0;
          cnt_d      = SETTLE_LOAD;
          fail_cnt_d = 3'd0;
          pass_d     = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        if (mismatch && (fail_cnt_q < 3'd4)) begin
          fail_cnt_d = fail_cnt_q + 3'd1;
        end
        if (v_q == 2'd3) begin
          state_d = DONE;
          // Include this last comparison, so pass is already valid in DONE.
          pass_d  = (fail_cnt_q == 3'd0) && !mismatch;
        end else begin
          state_d = SETTLE;
          v_d     = v_q + 2'd1;
          cnt_d   = SETTLE_LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    gt.busy  = 1'b0;
    gt.done  = 1'b0;
    gt.dut_a = 1'b0;
    gt.dut_b = 1'b0;
    case (state_q)
      SETTLE, SAMPLE: begin
        gt.busy  = 1'b1;
        gt.dut_a = v_q[1];
        gt.dut_b = v_q[0];
      end
      DONE: begin
        gt.done = 1'b1;
      end
      default: begin
        gt.busy = 1'b0;
      end
    endcase
  end

  assign gt.pass     = pass_q;
  assign gt.fail_cnt = fail_cnt_q;

`ifdef GATE_TESTER_FAILVEC_EN
  logic [1:0] fail_vec_q, fail_vec_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_vec_q <= 2'd0;
    end else begin
      fail_vec_q <= fail_vec_d;
    end
  end

  always_comb begin
    fail_vec_d = fail_vec_q;
    if ((state_q == IDLE) && gt.start) begin
      fail_vec_d = 2'd0;
    end else if (first_mismatch) begin
      fail_vec_d = v_q;
    end
  end

  assign gt.fail_vec = fail_vec_q;
`else
  logic unused_first_mismatch;
  assign unused_first_mismatch = first_mismatch;
  assign gt.fail_vec           = 2'b00;
`endif

endmodule

// File: tb/tb_gate_tester.sv
// Directed bench for gate_tester: gate models on dut_z, run timing, result and reset checks.
module tb_gate_tester;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;   // 0 OR, 1 AND, 2 stuck-1, 3 NOR, 4 XOR
  bit   sel = 1'b0; // 0: SETTLE_CYCLES=2 instance, 1: SETTLE_CYCLES=1 instance
  int   n_cmp = 0;
  int   n_mis = 0;

`ifdef GATE_TESTER_FAILVEC_EN
  localparam bit FV = 1'b1;
`else
  localparam bit FV = 1'b0;
`endif

  always #5 clk = ~clk;

  gate_tester_if g0 ();
  gate_tester_if g1 ();

  gate_tester #(.SETTLE_CYCLES(2)) u_dut0 (.clk(clk), .rst(rst), .gt(g0));
  gate_tester #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .gt(g1));

  function automatic logic gate_model(input int m, input logic a, input logic b);
    case (m)
      0:       return a | b;
      1:       return a & b;
      2:       return 1'b1;
      3:       return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  assign g0.dut_z = gate_model(mode, g0.dut_a, g0.dut_b);
  assign g1.dut_z = gate_model(mode, g1.dut_a, g1.dut_b);

  logic       m_a, m_b, m_busy, m_done, m_pass;
  logic [2:0] m_cnt;
  logic [1:0] m_vec;
  assign m_a    = sel ? g1.dut_a    : g0.dut_a;
  assign m_b    = sel ? g1.dut_b    : g0.dut_b;
  assign m_busy = sel ? g1.busy     : g0.busy;
  assign m_done = sel ? g1.done     : g0.done;
  assign m_pass = sel ? g1.pass     : g0.pass;
  assign m_cnt  = sel ? g1.fail_cnt : g0.fail_cnt;
  assign m_vec  = sel ? g1.fail_vec : g0.fail_vec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, {31'd0, g0.dut_a}, 32'd0);
    check({tag, "_misc"}, {24'd0, g0.dut_b, g0.busy, g0.done, g0.pass, g0.fail_cnt, g0.fail_vec[1]},
          32'd0);
    check({tag, "_vec"}, {30'd0, g0.fail_vec}, 32'd0);
  endtask

  // One start pulse; follows the run to its done pulse and checks results.
  task automatic run_one(input string tag, input bit s1, input int m, input int exp_edge,
                         input bit exp_pass, input logic [2:0] exp_cnt, input logic [1:0] exp_vec);
    int seen = 0;
    int seq_err = 0;
    int per = s1 ? 2 : 3;
    @(negedge clk);
    sel  = s1;
    mode = m;
    if (s1) g1.start = 1'b1; else g0.start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_clr"}, {28'd0, m_pass, m_cnt}, 32'd0);
    if (!m_busy || {m_a, m_b} != 2'd0) seq_err++;
    @(negedge clk);
    g0.start = 1'b0;
    g1.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (m_done) begin
        seen = n;
        break;
      end
      if (!m_busy || {m_a, m_b} != 2'(n / per)) seq_err++;
    end
    check({tag, "_edge"}, seen, exp_edge);
    check({tag, "_seq"}, seq_err, 0);
    check({tag, "_pass"}, {31'd0, m_pass}, {31'd0, exp_pass});
    check({tag, "_cnt"}, {29'd0, m_cnt}, {29'd0, exp_cnt});
    check({tag, "_vec"}, {30'd0, m_vec}, {30'd0, exp_vec & {2{FV}}});
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_hold"}, {26'd0, m_done, m_busy, m_pass, m_cnt},
          {26'd0, 1'b0, 1'b0, exp_pass, exp_cnt});
  endtask

  initial begin
    int first;
    int dcnt;
    int found;
    g0.start = 1'b0;
    g1.start = 1'b0;
    #12;
    check_idle_outputs("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    run_one("or",     1'b0, 0, 12, 1'b1, 3'd0, 2'b00);
    run_one("and",    1'b0, 1, 12, 1'b0, 3'd2, 2'b01);
    run_one("stuck",  1'b0, 2, 12, 1'b0, 3'd1, 2'b00);
    run_one("stuck1", 1'b1, 2,  8, 1'b0, 3'd1, 2'b00);
    run_one("nor",    1'b0, 3, 12, 1'b0, 3'd4, 2'b00);
    run_one("xor",    1'b0, 4, 12, 1'b0, 3'd1, 2'b11);
    run_one("or1",    1'b1, 0,  8, 1'b1, 3'd0, 2'b00);

    // start held high: one run, restart only once back in IDLE
    sel  = 1'b0;
    @(negedge clk);
    mode = 0;
    g0.start = 1'b1;
    @(posedge clk); #1;
    first = 0;
    dcnt  = 0;
    for (int n = 1; n <= 13; n++) begin
      @(posedge clk); #1;
      if (g0.done) begin
        dcnt++;
        if (first == 0) first = n;
      end
    end
    check("hold_first", first, 12);
    check("hold_dcnt", dcnt, 1);
    check("hold_idle", {31'd0, g0.busy}, 32'd0);
    @(posedge clk); #1;
    check("hold_restart", {31'd0, g0.busy}, 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    g0.start = 1'b0;
    found = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (g0.done) begin
        found = 1;
        break;
      end
    end
    check("hold_second_done", found, 1);
    @(posedge clk);

    // reset mid-run while v=2
    @(negedge clk);
    g0.start = 1'b1;
    @(negedge clk);
    g0.start = 1'b0;
    found = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (g0.dut_a && !g0.dut_b) begin
        found = 1;
        break;
      end
    end
    check("rst_reach_v2", found, 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    @(posedge clk); #2;
    rst = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (g0.done || g0.busy) dcnt++;
    end
    check("rst_no_done", dcnt, 0);
    check("rst_pass", {31'd0, g0.pass}, 32'd0);
    run_one("or_after", 1'b0, 0, 12, 1'b1, 3'd0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, limit 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
